// File: rtl/stages_definition_pkg.sv
// Shared pipeline-stage definitions used by the pixel write buffer.
// pix_write_t is one buffered pixel store (address + value); pwb_state_t is
// the presentation FSM of the buffer (IDLE: nothing offered, SEND: head
// entry offered on the frame-buffer port).
package stages_definition_pkg;

  localparam int PIX_ADDR_W = 32;
  localparam int PIX_DATA_W = 32;

  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [PIX_DATA_W-1:0] data;
  } pix_write_t;

  typedef enum logic {
    PWB_IDLE = 1'b0,
    PWB_SEND = 1'b1
  } pwb_state_t;

endpackage

// File: rtl/pixel_write_buffer_if.sv
// Frame-buffer port of the pixel write buffer: valid/ready handshake with
// address and data of the presented pixel write.
//   master: pixel_write_buffer (drives pix_valid/pix_addr/pix_data)
//   slave : frame-buffer side  (drives pix_ready)
interface pixel_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;

  modport master (output pix_valid, pix_addr, pix_data, input pix_ready);
  modport slave  (input pix_valid, pix_addr, pix_data, output pix_ready);
endinterface

// File: rtl/pix_fifo_mem.sv
// Storage array of the pixel write buffer: DEPTH x pix_write_t, one write
// port, one registered read port.
//   clk, reset    : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read strobe and address; rdata updates on the next edge
//   rdata         : registered read data
// A read of the slot being written in the same cycle returns the new data,
// so a push into an empty buffer can be presented one cycle later.
module pix_fifo_mem
  import stages_definition_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  pix_write_t    wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output pix_write_t    rdata
);

  pix_write_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      rdata <= '0;
    else if (re)
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// In-order buffer of pixel stores between the memory stage and the
// frame-buffer port.
//   clk, reset      : clock, synchronous active-low reset
//   wr_en/addr/data : pixel store from the exe_mem pipeline register
//   full            : stall request to hazard logic (count == DEPTH)
//   halt            : blocks launch of a new transaction
//   pix             : frame-buffer port (master side)
//   count           : occupied entries, presented one included
//   overflow        : sticky, a write was dropped while full
// The head entry is loaded into the registered read port whenever a new
// transaction launches, so pix_addr/pix_data hold still while waiting for
// pix_ready, independent of halt or incoming writes.
module pixel_write_buffer
  import stages_definition_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  input  logic                     halt,
  pixel_write_buffer_if.master     pix,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pwb_state_t    state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr, raddr;
  logic [CW-1:0] count_nxt;
  logic          push, pop, load;
  pix_write_t    wentry, rentry;

  assign pop  = (state == PWB_SEND) && pix.pix_ready;
  assign push = wr_en && ((count != CW'(DEPTH)) || pop);
  assign full = (count == CW'(DEPTH));

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // load: a new head must be captured into the read register this edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      PWB_IDLE: begin
        if ((count_nxt != '0) && !halt) begin
          state_nxt = PWB_SEND;
          load      = 1'b1;
        end
      end
      PWB_SEND: begin
        if (pop) begin
          if ((count_nxt != '0) && !halt) begin
            state_nxt = PWB_SEND;
            load      = 1'b1;
          end else begin
            state_nxt = PWB_IDLE;
          end
        end
      end
      default: state_nxt = PWB_IDLE;
    endcase
  end

  // After a pop the next head sits one slot past the current read pointer.
  assign raddr = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= PWB_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  assign wentry.addr = PIX_ADDR_W'(wr_addr);
  assign wentry.data = PIX_DATA_W'(wr_data);

  pix_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push && reset),
    .waddr (wr_ptr),
    .wdata (wentry),
    .re    (load),
    .raddr (raddr),
    .rdata (rentry)
  );

  assign pix.pix_valid = (state == PWB_SEND);
  assign pix.pix_addr  = ADDR_W'(rentry.addr);
  assign pix.pix_data  = DATA_W'(rentry.data);

endmodule

// File: tb/tb_pixel_write_buffer.sv
module tb_pixel_write_buffer;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset, wr_en, halt;
  logic [31:0] wr_addr, wr_data;
  logic        full, overflow;
  logic [3:0]  count;

  pixel_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) pif ();

  pixel_write_buffer #(.DEPTH(D), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .full     (full),
    .halt     (halt),
    .pix      (pif),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  // Reference: plain queue of accepted writes, a "presenting" flag and the
  // sticky drop flag.
  ent_t q[$];
  bit   mv, ov;
  int   n_tests, n_fail, n_pop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic h, input logic r);
    bit pop, room;
    ent_t e;
    reset = rst; wr_en = we; wr_addr = a; wr_data = d; halt = h; pif.pix_ready = r;
    if (!rst) begin
      q.delete(); mv = 0; ov = 0;
    end else begin
      pop  = mv && r;
      room = (q.size() < D) || pop;
      if (we && !room) ov = 1;
      if (pop) begin void'(q.pop_front()); n_pop++; end
      if (we && room) begin e.a = a; e.d = d; q.push_back(e); end
      if (!(mv && !pop)) mv = (q.size() > 0) && !h;
    end
    @(posedge clk); #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == D));
    chk("overflow", 64'(overflow), 64'(ov));
    chk("pix_valid", 64'(pif.pix_valid), 64'(mv));
    if (mv) begin
      chk("pix_addr", 64'(pif.pix_addr), 64'(q[0].a));
      chk("pix_data", 64'(pif.pix_data), 64'(q[0].d));
    end
  endtask

  task automatic idle(input int n, input logic h, input logic r);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, h, r);
  endtask

  task automatic do_reset();
    cycle(0, 1, 32'hDEAD, 32'hBEEF, 0, 1);
    chk("rst_addr", 64'(pif.pix_addr), 64'h0);
    chk("rst_data", 64'(pif.pix_data), 64'h0);
  endtask

  initial begin
    int acc, guard;
    n_tests = 0; n_fail = 0; n_pop = 0;
    mv = 0; ov = 0;

    do_reset();
    do_reset();

    // single write, latency 1, drained immediately
    cycle(1, 1, 32'h100, 32'hFF, 0, 1);
    chk("single_valid", 64'(pif.pix_valid), 64'h1);
    chk("single_addr", 64'(pif.pix_addr), 64'h100);
    idle(2, 0, 1);
    chk("single_cnt", 64'(count), 64'h0);

    // nine writes into a stalled port: ninth dropped, then ordered drain
    for (int i = 0; i < 9; i++) cycle(1, 1, 32'(i), 32'(i * 3 + 1), 0, 0);
    chk("fill_ovf", 64'(overflow), 64'h1);
    chk("fill_cnt", 64'(count), 64'h8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 64'(pif.pix_addr), 64'(i));
      cycle(1, 0, 0, 0, 0, 1);
    end
    chk("drain_empty", 64'(pif.pix_valid), 64'h0);
    do_reset();

    // full with simultaneous write and pop
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'h200 + 32'(i), 32'(i), 0, 0);
    cycle(1, 1, 32'h2FF, 32'h55, 0, 1);
    chk("fullpop_cnt", 64'(count), 64'h8);
    chk("fullpop_ovf", 64'(overflow), 64'h0);
    idle(12, 0, 1);
    do_reset();

    // halt while presenting: stable outputs, no relaunch after pop
    cycle(1, 1, 32'h300, 32'hA0, 0, 0);
    cycle(1, 1, 32'h301, 32'hA1, 0, 0);
    idle(3, 1, 0);
    chk("halt_hold", 64'(pif.pix_addr), 64'h300);
    cycle(1, 0, 0, 0, 1, 1);
    chk("halt_novalid", 64'(pif.pix_valid), 64'h0);
    idle(2, 1, 1);
    idle(3, 0, 1);
    do_reset();

    // 20 writes with random ready, pointer wrap
    n_pop = 0; acc = 0;
    while (acc < 20) begin
      logic r;
      logic w;
      r = 1'($urandom_range(0, 1));
      w = (q.size() < D) || (mv && r);
      cycle(1, w, 32'h400 + 32'(acc), $urandom, 0, r);
      if (w) acc++;
    end
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      cycle(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("drain20_bound", 64'(guard < 100), 64'h1);
    chk("drain20", 64'(n_pop), 64'd20);
    chk("drain20_ovf", 64'(overflow), 64'h0);

    // reset while presenting with five entries
    for (int i = 0; i < 5; i++) cycle(1, 1, 32'h500 + 32'(i), 32'(i), 0, 0);
    chk("pre_rst_cnt", 64'(count), 64'h5);
    do_reset();
    chk("rst_cnt", 64'(count), 64'h0);
    chk("rst_valid", 64'(pif.pix_valid), 64'h0);
    idle(4, 0, 1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), $urandom, $urandom,
            ($urandom_range(0, 9) < 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_buffer.md
PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of buffered pixel writes (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, pixel address width.
REQ-003 Parameter DATA_W, default 32, pixel data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 wr_en  input  1  pixel write request from memory stage (memPixWrite).
REQ-007 wr_addr  input  ADDR_W  pixel address (ALU result of the pixel store).
REQ-008 wr_data  input  DATA_W  pixel value.
REQ-009 full  output  1  buffer cannot accept a write this cycle unless a pop occurs; stall request to hazard logic.
REQ-010 halt  input  1  blocks launch of a new pixel transaction.
REQ-011 pix_valid  output  1  pixel transaction presented to frame-buffer port.
REQ-012 pix_addr  output  ADDR_W  address of presented transaction.
REQ-013 pix_data  output  DATA_W  data of presented transaction.
REQ-014 pix_ready  input  1  frame-buffer port accepts presented transaction.
REQ-015 count  output  clog2(DEPTH)+1  occupied entries, including the presented one.
REQ-016 overflow  output  1  sticky: a write was dropped.

Function
REQ-017 Push = wr_en and (count<DEPTH or pop); pop = pix_valid and pix_ready; both evaluated in the same cycle.
REQ-018 full SHALL equal (count==DEPTH), combinational from count.
REQ-019 Writes SHALL leave in arrival order; no reordering or merging.
REQ-020 Two-state FSM: IDLE (pix_valid=0), SEND (pix_valid=1).
REQ-021 IDLE->SEND when, at the clock edge, count>0 after update and halt=0; earliest pix_valid is the cycle after a push into an empty buffer (latency 1).
REQ-022 SEND->IDLE on pop when remaining count=0 or halt=1; SEND->SEND on pop with remaining entries and halt=0, presenting the next entry the next cycle (back-to-back throughput 1/cycle).
REQ-023 In SEND, pix_valid, pix_addr, pix_data SHALL stay stable until pop, regardless of halt.
REQ-024 pix_addr/pix_data SHALL be registered outputs (head entry), never combinational from wr_*.
REQ-025 Write while full without simultaneous pop: entry dropped, count unchanged, overflow set to 1 next cycle and held until reset.
REQ-026 Write while full with simultaneous pop: accepted, count stays DEPTH.
REQ-027 Simultaneous push and pop at any count: count unchanged.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.

Reset
REQ-029 When reset=0 at a clock edge: count=0, pointers=0, FSM=IDLE, pix_valid=0, pix_addr=0, pix_data=0, overflow=0, full=0.
REQ-030 Reset mid-transaction SHALL discard all buffered and presented entries; no pop is reported for the discarded transaction.
REQ-031 wr_en during the reset cycle SHALL be ignored.

Structure
REQ-032 Struct pix_write_t {addr, data} SHALL be added to stages_definition_pkg and used for storage entries.
REQ-033 Storage array SHALL be a sub-module pix_fifo_mem (DEPTH x pix_write_t, one write port, one registered read port); pointers, count and FSM stay in pixel_write_buffer.
REQ-034 Pipeline integration: full feeds the hazard stall path; wr_* come from exe_mem pipeline register pixel fields.

Verification
REQ-035 Single write addr=0x100 data=0xFF, pix_ready=1 -> pix_valid high exactly 1 cycle later with 0x100/0xFF, count returns to 0.
REQ-036 Nine writes addr 0..8 with pix_ready=0, DEPTH=8 -> full=1 after 8th, 9th dropped, overflow=1, count=8; then pix_ready=1 -> addresses 0..7 in order over 8 consecutive cycles.
REQ-037 Buffer full, wr_en=1 and pix_ready=1 same cycle -> write accepted, count stays 8, overflow stays 0.
REQ-038 pix_valid high, halt raised, pix_ready=0 for 3 cycles -> outputs stable; pix_ready=1 -> pop, pix_valid=0 next cycle while halt=1 despite count>0.
REQ-039 20 writes with random pix_ready toggling -> all 20 drained in order (pointer wrap covered), no duplicates.
REQ-040 Reset=0 asserted while count=5 and pix_valid=1 -> next cycle count=0, pix_valid=0, overflow=0; no further transactions presented.
